// File: rtl/lcd_pkg.sv
// Shared state encodings, command constants and helpers for the HD44780 4-bit nibble transmitter.
package lcd_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE       = 4'd0;
    localparam logic [STATE_W-1:0] ST_SETUP_H    = 4'd1;
    localparam logic [STATE_W-1:0] ST_PULSE_H    = 4'd2;
    localparam logic [STATE_W-1:0] ST_HOLD_H     = 4'd3;
    localparam logic [STATE_W-1:0] ST_SETUP_L    = 4'd4;
    localparam logic [STATE_W-1:0] ST_PULSE_L    = 4'd5;
    localparam logic [STATE_W-1:0] ST_HOLD_L     = 4'd6;
    localparam logic [STATE_W-1:0] ST_WAIT       = 4'd7;
    localparam logic [STATE_W-1:0] ST_INIT_PWR   = 4'd8;
    localparam logic [STATE_W-1:0] ST_INIT_SETUP = 4'd9;
    localparam logic [STATE_W-1:0] ST_INIT_PULSE = 4'd10;
    localparam logic [STATE_W-1:0] ST_INIT_HOLD  = 4'd11;
    localparam logic [STATE_W-1:0] ST_INIT_DLY   = 4'd12;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Power-on nibbles in send order; entry 0 sits in the low nibble.
    localparam logic [15:0] INIT_NIBBLES = 16'h2333;

    // Clear/home (0x01..0x03 with RS=0) need the long execution delay.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == (CMD_CLEAR | CMD_HOME));
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO buffering {RS, byte} writes ahead of the nibble engine.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_nibble_tx.sv
// HD44780 4-bit write engine: FIFO-buffered {RS, byte} writes sent as timed nibble pairs.
// Define LCD_INIT_SEQ_EN to add the power-on 0x3/0x3/0x3/0x2 init sequence.
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int E_LOW_CYC     = 1,
    parameter int E_HIGH_CYC    = 2,
    parameter int CMD_WAIT_CYC  = 40,
    parameter int LONG_WAIT_CYC = 1600,
    parameter int INIT_WAIT_CYC = 15000,
    parameter int FIFO_DEPTH    = 4
)(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic       IN_RS,
    input  logic [7:0] IN_DATA,
    output logic       RS,
    output logic       E,
    output logic       D4,
    output logic       D5,
    output logic       D6,
    output logic       D7,
    output logic       BUSY,
    output logic       INIT_DONE
);

    // state         | meaning
    // IDLE          | waiting for a queued byte; pops it into hold_q
    // SETUP_H/L     | RS and nibble driven, E low
    // PULSE_H/L     | E high, RS/D stable
    // HOLD_H/L      | E low again, RS/D stable
    // WAIT          | execution delay (long for clear/home)
    // INIT_PWR      | power-on delay before init nibbles
    // INIT_SETUP..  | single-nibble setup/pulse/hold of the init table
    // INIT_DLY      | delay after each init nibble

    localparam int MAX_CYC = max2(max2(max2(E_LOW_CYC, E_HIGH_CYC), max2(CMD_WAIT_CYC, LONG_WAIT_CYC)),
                                  INIT_WAIT_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int FCW     = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] LOAD_E_LOW  = CNT_W'(E_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_E_HIGH = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_CMD    = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_LONG   = CNT_W'(LONG_WAIT_CYC - 1);
`ifdef LCD_INIT_SEQ_EN
    localparam logic [STATE_W-1:0] ST_RESET  = ST_INIT_PWR;
    localparam logic [CNT_W-1:0]   CNT_RESET = CNT_W'(INIT_WAIT_CYC - 1);
`else
    localparam logic [STATE_W-1:0] ST_RESET  = ST_IDLE;
    localparam logic [CNT_W-1:0]   CNT_RESET = '0;
`endif

    logic [STATE_W-1:0] state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_load;
    logic               timer_done;
    logic [8:0]         hold_q;
    logic               init_done_q;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [8:0]         fifo_rd;
    logic [FCW-1:0]     fifo_count, fifo_cnt_nxt;

    logic               rs_q, e_q, busy_q;
    logic [3:0]         d_q;
    logic               rs_nxt, e_nxt, busy_nxt;
    logic [3:0]         d_nxt;

    assign fifo_push    = IN_VALID && !fifo_full;
    assign fifo_cnt_nxt = fifo_count + FCW'(fifo_push) - FCW'(fifo_pop);
    assign timer_done   = (cnt_q == '0);

    lcd_cmd_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push    (fifo_push),
        .wr_data ({IN_RS, IN_DATA}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_nxt;
        end
    end

    // One down-counter shared by every timed state, reloaded on each state entry.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= CNT_RESET;
        end else if (state_nxt != state_q) begin
            cnt_q <= cnt_load;
        end else if (!timer_done) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_q <= '0;
        end else if (fifo_pop) begin
            hold_q <= fifo_rd;
        end
    end

`ifdef LCD_INIT_SEQ_EN
    logic [1:0] init_idx_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
        end else if (state_q == ST_INIT_DLY && timer_done) begin
            init_idx_q <= init_idx_q + 2'd1;
            if (init_idx_q == 2'd3) init_done_q <= 1'b1;
        end
    end
`else
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt = state_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && init_done_q) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_SETUP_H;
                end
            end
            ST_SETUP_H: if (timer_done) state_nxt = ST_PULSE_H;
            ST_PULSE_H: if (timer_done) state_nxt = ST_HOLD_H;
            ST_HOLD_H:  if (timer_done) state_nxt = ST_SETUP_L;
            ST_SETUP_L: if (timer_done) state_nxt = ST_PULSE_L;
            ST_PULSE_L: if (timer_done) state_nxt = ST_HOLD_L;
            ST_HOLD_L:  if (timer_done) state_nxt = ST_WAIT;
            ST_WAIT:    if (timer_done) state_nxt = ST_IDLE;
`ifdef LCD_INIT_SEQ_EN
            ST_INIT_PWR:   if (timer_done) state_nxt = ST_INIT_SETUP;
            ST_INIT_SETUP: if (timer_done) state_nxt = ST_INIT_PULSE;
            ST_INIT_PULSE: if (timer_done) state_nxt = ST_INIT_HOLD;
            ST_INIT_HOLD:  if (timer_done) state_nxt = ST_INIT_DLY;
            ST_INIT_DLY: begin
                if (timer_done) state_nxt = (init_idx_q == 2'd3) ? ST_IDLE : ST_INIT_SETUP;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_load = '0;
        case (state_nxt)
            ST_SETUP_H, ST_HOLD_H, ST_SETUP_L, ST_HOLD_L,
            ST_INIT_SETUP, ST_INIT_HOLD:       cnt_load = LOAD_E_LOW;
            ST_PULSE_H, ST_PULSE_L, ST_INIT_PULSE: cnt_load = LOAD_E_HIGH;
            ST_WAIT: cnt_load = is_long_cmd(hold_q[8], hold_q[7:0]) ? LOAD_LONG : LOAD_CMD;
`ifdef LCD_INIT_SEQ_EN
            ST_INIT_DLY: cnt_load = (init_idx_q == 2'd0) ? LOAD_LONG : LOAD_CMD;
`endif
            default: cnt_load = '0;
        endcase
    end

    // Outputs are computed from the next state and registered, so pads never glitch.
    always_comb begin
        e_nxt    = (state_nxt == ST_PULSE_H) || (state_nxt == ST_PULSE_L) ||
                   (state_nxt == ST_INIT_PULSE);
        rs_nxt   = rs_q;
        d_nxt    = d_q;
        busy_nxt = (state_nxt != ST_IDLE) || (fifo_cnt_nxt != '0);
        if (state_nxt != state_q) begin
            case (state_nxt)
                ST_SETUP_H: begin
                    rs_nxt = fifo_rd[8];
                    d_nxt  = fifo_rd[7:4];
                end
                ST_SETUP_L: begin
                    rs_nxt = hold_q[8];
                    d_nxt  = hold_q[3:0];
                end
`ifdef LCD_INIT_SEQ_EN
                ST_INIT_SETUP: begin
                    rs_nxt = 1'b0;
                    d_nxt  = INIT_NIBBLES[{init_idx_q, 2'b00} +: 4];
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rs_q   <= 1'b0;
            e_q    <= 1'b0;
            d_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            rs_q   <= rs_nxt;
            e_q    <= e_nxt;
            d_q    <= d_nxt;
            busy_q <= busy_nxt;
        end
    end

    assign IN_READY  = !fifo_full;
    assign RS        = rs_q;
    assign E         = e_q;
    assign D4        = d_q[0];
    assign D5        = d_q[1];
    assign D6        = d_q[2];
    assign D7        = d_q[3];
    assign BUSY      = busy_q;
    assign INIT_DONE = init_done_q;

endmodule

// File: tb/tb_lcd_nibble_tx.sv
// Scoreboard bench for lcd_nibble_tx: stimulus queues expected nibble pulses, a monitor checks each E pulse.
module tb_lcd_nibble_tx;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       IN_VALID = 1'b0;
    logic       IN_RS = 1'b0;
    logic [7:0] IN_DATA = 8'h00;
    logic       IN_READY, RS, E, D4, D5, D6, D7, BUSY, INIT_DONE;
    logic [3:0] d_bus;

    typedef struct {
        logic       rs;
        logic [3:0] nib;
        int         min_gap;
    } pulse_t;

    pulse_t exp_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     next_gap = 0;

    always #5 CLK = ~CLK;

    assign d_bus = {D7, D6, D5, D4};

    lcd_nibble_tx #(
        .E_LOW_CYC     (1),
        .E_HIGH_CYC    (2),
        .CMD_WAIT_CYC  (4),
        .LONG_WAIT_CYC (20),
        .INIT_WAIT_CYC (10),
        .FIFO_DEPTH    (4)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_RS     (IN_RS),
        .IN_DATA   (IN_DATA),
        .RS        (RS),
        .E         (E),
        .D4        (D4),
        .D5        (D5),
        .D6        (D6),
        .D7        (D7),
        .BUSY      (BUSY),
        .INIT_DONE (INIT_DONE)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Each byte becomes two pulses; the gap before the high nibble depends on the previous byte.
    task automatic expect_byte(input logic rs, input logic [7:0] d);
        pulse_t p;
        p.rs = rs; p.nib = d[7:4]; p.min_gap = next_gap;
        exp_q.push_back(p);
        p.nib = d[3:0]; p.min_gap = 2;
        exp_q.push_back(p);
        next_gap = (!rs && d >= 8'h01 && d <= 8'h03) ? 22 : 6;
    endtask

    task automatic expect_init();
`ifdef LCD_INIT_SEQ_EN
        pulse_t p;
        p.rs = 1'b0; p.nib = 4'h3; p.min_gap = 0;
        exp_q.push_back(p);
        p.min_gap = 22;
        exp_q.push_back(p);
        p.min_gap = 6;
        exp_q.push_back(p);
        p.nib = 4'h2;
        exp_q.push_back(p);
        next_gap = 6;
`endif
    endtask

    task automatic send(input logic rs, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge CLK);
        IN_VALID = 1'b1; IN_RS = rs; IN_DATA = d;
        while (!IN_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: IN_READY stayed 0 for %0d cycles, required 1", n);
        end else begin
            expect_byte(rs, d);
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((BUSY || exp_q.size() != 0) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        n_checks++;
        if (n >= 2000) begin
            n_fail++;
            $display("FAIL %s_drain: busy=%0d pending=%0d after %0d cycles, required 0 and 0",
                     tag, BUSY, exp_q.size(), n);
        end
    endtask

    // Monitor: pops the scoreboard on every E rise, checks pulse width, stability and gap.
    logic       prev_e = 1'b0;
    logic       have_fall = 1'b0;
    int         high_cnt = 0;
    int         low_cnt = 0;
    logic       cur_rs = 1'b0;
    logic [3:0] cur_d = 4'h0;

    always @(negedge CLK) begin : monitor
        pulse_t p;
        if (!RST_N) begin
            prev_e = 1'b0; have_fall = 1'b0; high_cnt = 0; low_cnt = 0;
        end else begin
            if (E && !prev_e) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_pulse: got rs=%0d d=%0h, required no pulse", RS, d_bus);
                end else begin
                    p = exp_q.pop_front();
                    check("pulse_rs", int'(RS), int'(p.rs));
                    check("pulse_nibble", int'(d_bus), int'(p.nib));
                    if (have_fall && p.min_gap > 0) begin
                        n_checks++;
                        if (low_cnt + 1 < p.min_gap) begin
                            n_fail++;
                            $display("FAIL pulse_gap: got %0d cycles, required >= %0d", low_cnt + 1, p.min_gap);
                        end
                    end
                end
                high_cnt = 1; cur_rs = RS; cur_d = d_bus;
            end else if (E && prev_e) begin
                high_cnt++;
                check("pulse_stable", int'({RS, d_bus}), int'({cur_rs, cur_d}));
            end else if (!E && prev_e) begin
                check("e_high_cycles", high_cnt, 2);
                have_fall = 1'b1;
                low_cnt = 0;
            end else begin
                low_cnt++;
            end
            prev_e = E;
        end
    end

    initial begin : stim
        int acc;
        int n;

        #1 RST_N = 1'b0;
        #1;
        check("rst_rs", int'(RS), 0);
        check("rst_e", int'(E), 0);
        check("rst_d", int'(d_bus), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_init_done", int'(INIT_DONE), 0);
        check("rst_in_ready", int'(IN_READY), 1);

        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        expect_init();

        // Byte written right after reset: init nibbles (if built in) come first.
        send(1'b1, 8'h41);
`ifdef LCD_INIT_SEQ_EN
        check("init_done_during_init", int'(INIT_DONE), 0);
`else
        check("init_done_after_clk", int'(INIT_DONE), 1);
`endif
        wait_idle("first");
        check("init_done_final", int'(INIT_DONE), 1);

        // Character byte, then a second one queued behind it.
        send(1'b1, 8'h48);
        send(1'b1, 8'h49);
        wait_idle("chars");

        // Clear and 0x03 use the long execution delay.
        send(1'b0, 8'h01);
        send(1'b1, 8'h41);
        wait_idle("clear");
        send(1'b0, 8'h03);
        send(1'b1, 8'h42);
        wait_idle("cmd03");
        send(1'b0, 8'h28);
        send(1'b1, 8'h43);
        wait_idle("cmd28");

        // Burst while idle: FIFO fills after five writes.
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            IN_VALID = 1'b1; IN_RS = 1'b1; IN_DATA = 8'h30 + 8'(i);
            if (i == 5) check("burst_ready_low_6th", int'(IN_READY), 0);
            if (IN_READY) begin
                acc++;
                expect_byte(1'b1, IN_DATA);
            end
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
        check("burst_accepted", acc, 5);
        wait_idle("burst");

        // Reset in the middle of a pulse with another byte still queued.
        send(1'b1, 8'h5A);
        send(1'b1, 8'h6B);
        n = 0;
        while (!E && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("reset_saw_pulse", int'(E), 1);
        #1 RST_N = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_e", int'(E), 0);
        check("midrst_rs", int'(RS), 0);
        check("midrst_d", int'(d_bus), 0);
        check("midrst_busy", int'(BUSY), 0);
        check("midrst_ready", int'(IN_READY), 1);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        expect_init();
        repeat (40) @(negedge CLK);
        wait_idle("post_reset");
        check("post_reset_busy", int'(BUSY), 0);
        check("post_reset_init_done", int'(INIT_DONE), 1);

        send(1'b1, 8'h7C);
        wait_idle("after_reset_byte");

        repeat (5) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
